// File: rtl/lsu_mem_master_if.sv
// Core-side request/response and word-addressed memory port of the load/store initiator.
// The master modport is the initiator's own view; slave is the core/memory side.
interface lsu_mem_master_if #(
   parameter int ADDR_W = 30
);
   logic              req_valid;
   logic              req_ready;
   logic              req_store;
   logic [2:0]        req_funct3;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_error;
   logic [ADDR_W-1:0] mem_address;
   logic [3:0]        mem_byteena;
   logic [31:0]       mem_data;
   logic              mem_wren;
   logic [31:0]       mem_q;

   modport master (
      input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_q,
      output req_ready, rsp_valid, rsp_rdata, rsp_error,
             mem_address, mem_byteena, mem_data, mem_wren
   );

   modport slave (
      output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_q,
      input  req_ready, rsp_valid, rsp_rdata, rsp_error,
             mem_address, mem_byteena, mem_data, mem_wren
   );
endinterface

// File: rtl/lsu_mem_master.sv
// RV32 load/store initiator: byte address to word accesses, splitting word-straddling
// accesses in two, merging read words and sign/zero-extending the load result.
module lsu_mem_master #(
   parameter int ADDR_W = 30
) (
   input  logic              clock,
   input  logic              reset_n,
   lsu_mem_master_if.master  bus
);
   typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_RESP} state_t;

   state_t            r_state, w_next;
   logic              r_store, r_err;
   logic [2:0]        r_f3;
   logic [31:0]       r_addr, r_wdata, r_lo, r_hi;

   logic              w_accept, w_illegal, w_split, w_sgn;
   logic [1:0]        w_off;
   logic [3:0]        w_wmask;
   logic [7:0]        w_lanes;
   logic [63:0]       w_wd64;
   logic [31:0]       w_r, w_ext;
   logic [ADDR_W-1:0] w_word0, w_word1;

   assign w_accept  = bus.req_valid && (r_state == S_IDLE);
   assign w_illegal = bus.req_store ? (bus.req_funct3 >= 3'b011)
                                    : (bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11);

   // Geometry is decoded from the captured request, so mem_* never sees req_* combinationally.
   assign w_off = r_addr[1:0];
   always_comb begin
      w_wmask = 4'b1111;
      case (r_f3[1:0])
         2'b00:   w_wmask = 4'b0001;
         2'b01:   w_wmask = 4'b0011;
         default: w_wmask = 4'b1111;
      endcase
   end
   assign w_lanes = {4'b0000, w_wmask} << w_off;
   assign w_split = |w_lanes[7:4];
   assign w_wd64  = {32'b0, r_wdata} << {w_off, 3'b000};
   assign w_word0 = r_addr[ADDR_W+1:2];
   assign w_word1 = w_word0 + ADDR_W'(1);
   assign w_r     = 32'({r_hi, r_lo} >> {w_off, 3'b000});
   assign w_sgn   = ~r_f3[2];

   always_comb begin
      w_ext = w_r;
      case (r_f3[1:0])
         2'b00:   w_ext = {{24{w_sgn & w_r[7]}},  w_r[7:0]};
         2'b01:   w_ext = {{16{w_sgn & w_r[15]}}, w_r[15:0]};
         default: w_ext = w_r;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next = w_illegal ? S_RESP : S_ACC0;
         S_ACC0: w_next = w_split ? S_ACC1 : S_RESP;
         S_ACC1: w_next = S_RESP;
         S_RESP: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_store <= 1'b0;
         r_err   <= 1'b0;
         r_f3    <= 3'b0;
         r_addr  <= 32'b0;
         r_wdata <= 32'b0;
         r_lo    <= 32'b0;
         r_hi    <= 32'b0;
      end else begin
         if (w_accept) begin
            r_store <= bus.req_store;
            r_err   <= w_illegal;
            r_f3    <= bus.req_funct3;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_hi    <= 32'b0;
         end
         if (r_state == S_ACC0) r_lo <= bus.mem_q;
         if (r_state == S_ACC1) r_hi <= bus.mem_q;
      end
   end

   always_comb begin
      bus.req_ready   = 1'b0;
      bus.rsp_valid   = 1'b0;
      bus.rsp_rdata   = 32'b0;
      bus.rsp_error   = 1'b0;
      bus.mem_address = '0;
      bus.mem_byteena = 4'b0;
      bus.mem_data    = 32'b0;
      bus.mem_wren    = 1'b0;
      case (r_state)
         S_IDLE: bus.req_ready = 1'b1;
         S_ACC0: begin
            bus.mem_address = w_word0;
            bus.mem_byteena = w_lanes[3:0];
            bus.mem_data    = w_wd64[31:0];
            bus.mem_wren    = r_store;
         end
         S_ACC1: begin
            bus.mem_address = w_word1;
            bus.mem_byteena = w_lanes[7:4];
            bus.mem_data    = w_wd64[63:32];
            bus.mem_wren    = r_store;
         end
         S_RESP: begin
            bus.rsp_valid = 1'b1;
            bus.rsp_error = r_err;
            bus.rsp_rdata = (r_store || r_err) ? 32'b0 : w_ext;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master against a 16-word byte-enabled memory model.
module tb_lsu_mem_master;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] mem [16];
   int          n_cmp = 0;
   int          n_mis = 0;

   lsu_mem_master_if #(.ADDR_W(30)) bus ();
   lsu_mem_master #(.ADDR_W(30)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

   always #5 clock = ~clock;

   assign bus.mem_q = mem[bus.mem_address[3:0]];

   always @(posedge clock) begin
      if (bus.mem_wren)
         for (int b = 0; b < 4; b++)
            if (bus.mem_byteena[b]) mem[bus.mem_address[3:0]][8*b +: 8] <= bus.mem_data[8*b +: 8];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // per-transaction capture
   int          lat;
   logic [31:0] rsp_d;
   logic        rsp_e;
   int          acc_n;
   logic [29:0] acc_a [2];
   logic [3:0]  acc_b [2];
   logic [31:0] acc_d [2];
   logic        wr_any;

   task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd);
      @(negedge clock);
      chk("ready_before_req", bus.req_ready, 1);
      bus.req_valid  = 1'b1;
      bus.req_store  = st;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wd;
      @(posedge clock);
      #1 bus.req_valid = 1'b0;
      lat = 0; rsp_d = 32'hx; rsp_e = 1'bx; acc_n = 0; wr_any = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clock);
         if (bus.mem_wren) wr_any = 1'b1;
         if (bus.mem_byteena != 4'b0 && acc_n < 2) begin
            acc_a[acc_n] = bus.mem_address;
            acc_b[acc_n] = bus.mem_byteena;
            acc_d[acc_n] = bus.mem_data;
            acc_n++;
         end
         if (bus.rsp_valid) begin
            lat = n; rsp_d = bus.rsp_rdata; rsp_e = bus.rsp_error;
            break;
         end
      end
   endtask

   initial begin
      logic rv_seen;
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'b0;
      bus.req_addr = 32'b0; bus.req_wdata = 32'b0;
      repeat (2) @(negedge clock);
      chk("rst_ready", bus.req_ready, 1);
      chk("rst_rsp", {bus.rsp_valid, bus.rsp_error, bus.rsp_rdata}, 0);
      chk("rst_mem", {bus.mem_wren, bus.mem_byteena, bus.mem_address, bus.mem_data}, 0);
      reset_n = 1'b1;

      // aligned store word
      run(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
      chk("sw_lat", lat, 2);
      chk("sw_rsp", {rsp_e, rsp_d}, 0);
      chk("sw_accn", acc_n, 1);
      chk("sw_acc", {acc_a[0], acc_b[0], acc_d[0]}, {30'd4, 4'b1111, 32'hDEADBEEF});
      chk("sw_wren", wr_any, 1);
      chk("sw_mem4", mem[4], 32'hDEADBEEF);

      // sub-word loads
      mem[4] = 32'h80FF1234;
      run(1'b0, 3'b000, 32'h13, 32'h0);
      chk("lb_lat", lat, 2);
      chk("lb_data", {rsp_e, rsp_d}, {1'b0, 32'hFFFFFF80});
      chk("lb_wren", wr_any, 0);
      run(1'b0, 3'b100, 32'h13, 32'h0);
      chk("lbu_data", {rsp_e, rsp_d}, {1'b0, 32'h00000080});
      chk("lbu_wren", wr_any, 0);
      run(1'b0, 3'b001, 32'h12, 32'h0);
      chk("lh_data", {rsp_e, rsp_d}, {1'b0, 32'hFFFF80FF});
      chk("lh_acc", {acc_a[0], acc_b[0]}, {30'd4, 4'b1100});
      run(1'b0, 3'b101, 32'h12, 32'h0);
      chk("lhu_data", rsp_d, 32'h000080FF);

      // split load word
      mem[3] = 32'h44332211; mem[4] = 32'h88776655;
      run(1'b0, 3'b010, 32'h0E, 32'h0);
      chk("lwsp_lat", lat, 3);
      chk("lwsp_data", {rsp_e, rsp_d}, {1'b0, 32'h66554433});
      chk("lwsp_accn", acc_n, 2);
      chk("lwsp_a0", {acc_a[0], acc_b[0]}, {30'd3, 4'b1100});
      chk("lwsp_a1", {acc_a[1], acc_b[1]}, {30'd4, 4'b0011});
      chk("lwsp_wren", wr_any, 0);

      // split store half
      run(1'b1, 3'b001, 32'h0F, 32'h0000ABCD);
      chk("shsp_lat", lat, 3);
      chk("shsp_a0", {acc_a[0], acc_b[0], acc_d[0]}, {30'd3, 4'b1000, 32'hCD000000});
      chk("shsp_a1", {acc_a[1], acc_b[1], acc_d[1]}, {30'd4, 4'b0001, 32'h000000AB});
      chk("shsp_mem3", mem[3], 32'hCD332211);
      chk("shsp_mem4", mem[4], 32'h887766AB);

      // word-address wrap past the top of the address space
      mem[15] = 32'hA1A2A3A4; mem[0] = 32'hB1B2B3B4;
      run(1'b0, 3'b010, 32'hFFFFFFFD, 32'h0);
      chk("wrap_lat", lat, 3);
      chk("wrap_addr", {acc_a[0], acc_a[1]}, {30'h3FFFFFFF, 30'h0});
      chk("wrap_data", rsp_d, 32'hB4A1A2A3);

      // illegal funct3
      run(1'b0, 3'b011, 32'h10, 32'h0);
      chk("illld_lat", lat, 1);
      chk("illld_rsp", {rsp_e, rsp_d}, {1'b1, 32'h0});
      chk("illld_noacc", {acc_n, wr_any}, 0);
      run(1'b1, 3'b011, 32'h10, 32'hFFFFFFFF);
      chk("illst_lat", lat, 1);
      chk("illst_rsp", {rsp_e, rsp_d}, {1'b1, 32'h0});
      chk("illst_noacc", {acc_n, wr_any}, 0);

      // reset during ACC1 of a split store
      @(negedge clock);
      bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b010;
      bus.req_addr = 32'h0E; bus.req_wdata = 32'h12345678;
      @(posedge clock);
      #1 bus.req_valid = 1'b0;
      @(posedge clock);
      #2 chk("abort_acc1_wren", bus.mem_wren, 1);
      reset_n = 1'b0;
      #1 chk("abort_wren_drop", {bus.mem_wren, bus.mem_byteena, bus.rsp_valid}, 0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      rv_seen = 1'b0;
      for (int n = 0; n < 4; n++) begin
         @(negedge clock);
         if (bus.rsp_valid) rv_seen = 1'b1;
      end
      chk("abort_norsp", rv_seen, 0);
      chk("abort_ready", bus.req_ready, 1);
      chk("abort_mem3", mem[3], 32'h56782211);
      chk("abort_mem4", mem[4], 32'h887766AB);
      run(1'b0, 3'b010, 32'h10, 32'h0);
      chk("post_lw_lat", lat, 2);
      chk("post_lw_data", {rsp_e, rsp_d}, {1'b0, 32'h887766AB});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
